// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, sequencer states and control-line masks shared by the control unit and datapath.
package cpu_pkg;
  localparam logic [4:0] OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010, OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100, OP_AND = 5'b00101, OP_OR = 5'b00110, OP_ROR = 5'b00111;
  localparam logic [4:0] OP_ROL = 5'b01000, OP_SHR = 5'b01001, OP_SHRA = 5'b01010, OP_SHL = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100, OP_ANDI = 5'b01101, OP_ORI = 5'b01110, OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000, OP_NEG = 5'b10001, OP_NOT = 5'b10010, OP_BR = 5'b10011;
  localparam logic [4:0] OP_JR = 5'b10100, OP_JAL = 5'b10101, OP_IN = 5'b10110, OP_OUT = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000, OP_MFLO = 5'b11001, OP_NOP = 5'b11010, OP_HALT = 5'b11011;
  // Steps within one instruction are consecutive codes so the sequencer can simply increment.
  typedef enum logic [5:0] {
    S_RST, S_F0, S_F1, S_F2, S_F3, S_D0, S_HALT,
    S_RR0, S_RR1, S_RR2, S_RI0, S_RI1, S_RI2, S_LDI0, S_LDI1, S_LDI2,
    S_LD0, S_LD1, S_LD2, S_LD3, S_LD4, S_LD5, S_ST0, S_ST1, S_ST2, S_ST3, S_ST4,
    S_MD0, S_MD1, S_MD2, S_MD3, S_NN0, S_NN1, S_BR0, S_BR1, S_BR2, S_BR3,
    S_JR, S_JAL0, S_JAL1, S_IN, S_OUT, S_MFHI, S_MFLO, S_NOP
  } state_t;
  localparam logic [26:0] C_HI_IN = 27'd1 << 26, C_LO_IN = 27'd1 << 25, C_PC_IN = 27'd1 << 24;
  localparam logic [26:0] C_MDR_IN = 27'd1 << 23, C_OUTPORT_IN = 27'd1 << 22, C_Z_IN = 27'd1 << 21;
  localparam logic [26:0] C_Y_IN = 27'd1 << 20, C_MAR_IN = 27'd1 << 19, C_IR_IN = 27'd1 << 18;
  localparam logic [26:0] C_CON_IN = 27'd1 << 17, C_HI_OUT = 27'd1 << 16, C_LO_OUT = 27'd1 << 15;
  localparam logic [26:0] C_ZHI_OUT = 27'd1 << 14, C_ZLO_OUT = 27'd1 << 13, C_PC_OUT = 27'd1 << 12;
  localparam logic [26:0] C_MDR_OUT = 27'd1 << 11, C_INPORT_OUT = 27'd1 << 10, C_C_OUT = 27'd1 << 9;
  localparam logic [26:0] C_GRA = 27'd1 << 8, C_GRB = 27'd1 << 7, C_GRC = 27'd1 << 6;
  localparam logic [26:0] C_RIN = 27'd1 << 5, C_ROUT = 27'd1 << 4, C_BA_OUT = 27'd1 << 3;
  localparam logic [26:0] C_READ = 27'd1 << 2, C_WRITE = 27'd1 << 1, C_INC_PC = 27'd1 << 0;
  function automatic state_t entry_state(input logic [4:0] op);
    case (op)
      OP_LD: entry_state = S_LD0;
      OP_LDI: entry_state = S_LDI0;
      OP_ST: entry_state = S_ST0;
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL: entry_state = S_RR0;
      OP_ADDI, OP_ANDI, OP_ORI: entry_state = S_RI0;
      OP_MUL, OP_DIV: entry_state = S_MD0;
      OP_NEG, OP_NOT: entry_state = S_NN0;
      OP_BR: entry_state = S_BR0;
      OP_JR: entry_state = S_JR;
      OP_JAL: entry_state = S_JAL0;
      OP_IN: entry_state = S_IN;
      OP_OUT: entry_state = S_OUT;
      OP_MFHI: entry_state = S_MFHI;
      OP_MFLO: entry_state = S_MFLO;
      OP_HALT: entry_state = S_HALT;
      default: entry_state = S_NOP;
    endcase
  endfunction
endpackage

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute control unit driving every datapath control line.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] IR,
  input  logic        CON,
  input  logic        Stop,
  output logic        Run,
  output logic        HIin, LOin, PCin, MDRin, OUTPORTin, Zin, Yin, MARin, IRin, CONin,
  output logic        HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic        Read, write, IncPC
);
  state_t r_state, w_next;
  logic [26:0] w_ctl;
  logic w_last;
  assign w_last = r_state inside {S_RR2, S_RI2, S_LDI2, S_LD5, S_ST4, S_MD3, S_NN1, S_BR3,
                                  S_JR, S_JAL1, S_IN, S_OUT, S_MFHI, S_MFLO, S_NOP};
  always_comb begin
    w_next = state_t'(r_state + 6'd1);
    if (r_state == S_HALT) w_next = S_HALT;
    else if (r_state == S_D0) w_next = entry_state(IR[31:27]);
    else if (w_last) w_next = Stop ? S_HALT : S_F0;
  end
  always_ff @(posedge Clock) r_state <= Reset ? S_RST : w_next;
  always_comb begin
    w_ctl = '0;
    case (r_state)
      S_F0: w_ctl = C_PC_OUT | C_MAR_IN | C_INC_PC | C_Z_IN;
      S_F1: w_ctl = C_ZLO_OUT | C_PC_IN | C_READ;
      S_F2: w_ctl = C_READ | C_MDR_IN;
      S_F3: w_ctl = C_MDR_OUT | C_IR_IN;
      S_RR0, S_RI0: w_ctl = C_GRB | C_ROUT | C_Y_IN;
      S_RR1: w_ctl = C_GRC | C_ROUT | C_Z_IN;
      S_RI1, S_LDI1, S_LD1, S_ST1, S_BR2: w_ctl = C_C_OUT | C_Z_IN;
      S_RR2, S_RI2, S_LDI2: w_ctl = C_ZLO_OUT | C_GRA | C_RIN;
      S_LDI0, S_LD0, S_ST0: w_ctl = C_GRB | C_BA_OUT | C_Y_IN;
      S_LD2, S_ST2: w_ctl = C_ZLO_OUT | C_MAR_IN;
      S_LD3: w_ctl = C_READ;
      S_LD4: w_ctl = C_READ | C_MDR_IN;
      S_LD5: w_ctl = C_MDR_OUT | C_GRA | C_RIN;
      S_ST3: w_ctl = C_GRA | C_ROUT | C_MDR_IN;
      S_ST4: w_ctl = C_WRITE;
      S_MD0: w_ctl = C_GRA | C_ROUT | C_Y_IN;
      S_MD1, S_NN0: w_ctl = C_GRB | C_ROUT | C_Z_IN;
      S_MD2: w_ctl = C_ZLO_OUT | C_LO_IN;
      S_MD3: w_ctl = C_ZHI_OUT | C_HI_IN;
      S_NN1: w_ctl = C_ZLO_OUT | C_GRA | C_RIN;
      S_BR0: w_ctl = C_GRA | C_ROUT | C_CON_IN;
      S_BR1: w_ctl = C_PC_OUT | C_Y_IN;
      S_BR3: w_ctl = CON ? (C_ZLO_OUT | C_PC_IN) : '0;
      S_JR: w_ctl = C_GRA | C_ROUT | C_PC_IN;
      S_JAL0: w_ctl = C_PC_OUT | C_GRA | C_RIN;
      S_JAL1: w_ctl = C_GRB | C_ROUT | C_PC_IN;
      S_IN: w_ctl = C_INPORT_OUT | C_GRA | C_RIN;
      S_OUT: w_ctl = C_GRA | C_ROUT | C_OUTPORT_IN;
      S_MFHI: w_ctl = C_HI_OUT | C_GRA | C_RIN;
      S_MFLO: w_ctl = C_LO_OUT | C_GRA | C_RIN;
      default: w_ctl = '0;
    endcase
  end
  // Reset silences the lines immediately so an in-flight write cannot complete.
  assign {HIin, LOin, PCin, MDRin, OUTPORTin, Zin, Yin, MARin, IRin, CONin,
          HIout, LOout, ZHIout, ZLOout, PCout, MDRout, INPORTout, Cout,
          Gra, Grb, Grc, Rin, Rout, BAout, Read, write, IncPC} = Reset ? '0 : w_ctl;
  assign Run = Reset || r_state != S_HALT;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed per-cycle vectors checked through a scoreboard queue.
module tb_control_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] ir = '0;
  logic con = 1'b0, stop = 1'b0;
  logic run, hi_in, lo_in, pc_in, mdr_in, outport_in, z_in, y_in, mar_in, ir_in, con_in;
  logic hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out;
  logic gra, grb, grc, r_in, r_out, ba_out, rd, wr, inc_pc;
  always #5 clk = ~clk;
  control_sequencer dut (
    .Clock(clk), .Reset(rst), .IR(ir), .CON(con), .Stop(stop), .Run(run),
    .HIin(hi_in), .LOin(lo_in), .PCin(pc_in), .MDRin(mdr_in), .OUTPORTin(outport_in),
    .Zin(z_in), .Yin(y_in), .MARin(mar_in), .IRin(ir_in), .CONin(con_in),
    .HIout(hi_out), .LOout(lo_out), .ZHIout(zhi_out), .ZLOout(zlo_out), .PCout(pc_out),
    .MDRout(mdr_out), .INPORTout(inport_out), .Cout(c_out),
    .Gra(gra), .Grb(grb), .Grc(grc), .Rin(r_in), .Rout(r_out), .BAout(ba_out),
    .Read(rd), .write(wr), .IncPC(inc_pc)
  );
  localparam logic [27:0] R = 28'd1 << 27, HII = 28'd1 << 26, LOI = 28'd1 << 25, PCI = 28'd1 << 24;
  localparam logic [27:0] MDRI = 28'd1 << 23, OPI = 28'd1 << 22, ZI = 28'd1 << 21, YI = 28'd1 << 20;
  localparam logic [27:0] MARI = 28'd1 << 19, IRI = 28'd1 << 18, CONI = 28'd1 << 17, HIO = 28'd1 << 16;
  localparam logic [27:0] LOO = 28'd1 << 15, ZHIO = 28'd1 << 14, ZLOO = 28'd1 << 13, PCO = 28'd1 << 12;
  localparam logic [27:0] MDRO = 28'd1 << 11, INPO = 28'd1 << 10, CO = 28'd1 << 9, GA = 28'd1 << 8;
  localparam logic [27:0] GB = 28'd1 << 7, GC = 28'd1 << 6, RIN = 28'd1 << 5, ROUT = 28'd1 << 4;
  localparam logic [27:0] BAO = 28'd1 << 3, RD = 28'd1 << 2, WR = 28'd1 << 1, INC = 28'd1 << 0;
  localparam logic [31:0] I_LD = 32'h0000_0000, I_ST = 32'h1000_0000, I_ADD = 32'h1880_0000;
  localparam logic [31:0] I_MUL = 32'h7800_0000, I_BR = 32'h9800_0000, I_JR = 32'hA000_0000;
  localparam logic [31:0] I_JAL = 32'hA800_0000, I_NOP = 32'hD000_0000, I_HALT = 32'hD800_0000;
  localparam logic [31:0] I_UND = 32'hF800_0000;
  typedef struct { logic [27:0] vec; string name; } exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  logic [27:0] obs;
  assign obs = {run, hi_in, lo_in, pc_in, mdr_in, outport_in, z_in, y_in, mar_in, ir_in, con_in,
                hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out,
                gra, grb, grc, r_in, r_out, ba_out, rd, wr, inc_pc};
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (obs !== e.vec) begin
        failures++;
        $display("FAIL %s: got=%07h exp=%07h at %0t", e.name, obs, e.vec, $time);
      end
    end
  end
  task automatic cyc(input logic r, input logic [31:0] i, input logic c, input logic s,
                     input logic [27:0] v, input string n);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; ir = i; con = c; stop = s;
    e.vec = v; e.name = n;
    q.push_back(e);
  endtask
  task automatic fetch(input logic [31:0] i, input string n);
    cyc(0, i, 0, 0, R | PCO | MARI | INC | ZI, {n, "_f0"});
    cyc(0, i, 0, 0, R | ZLOO | PCI | RD, {n, "_f1"});
    cyc(0, i, 0, 0, R | RD | MDRI, {n, "_f2"});
    cyc(0, i, 0, 0, R | MDRO | IRI, {n, "_f3"});
    cyc(0, i, 0, 0, R, {n, "_d0"});
  endtask
  task automatic reset_release(input int n);
    for (int k = 0; k < n; k++) cyc(1, I_NOP, 0, 0, R, "reset");
    cyc(0, I_NOP, 0, 0, R, "rst_state");
  endtask
  initial begin
    reset_release(3);
    fetch(I_NOP, "nop");
    cyc(0, I_NOP, 0, 0, R, "nop_e0");
    fetch(I_ADD, "add");
    cyc(0, I_ADD, 0, 1, R | GB | ROUT | YI, "add_e0");
    cyc(0, I_ADD, 0, 1, R | GC | ROUT | ZI, "add_e1");
    cyc(0, I_ADD, 0, 0, R | ZLOO | GA | RIN, "add_e2");
    fetch(I_LD, "ld");
    cyc(0, I_LD, 0, 0, R | GB | BAO | YI, "ld_e0");
    cyc(0, I_LD, 0, 0, R | CO | ZI, "ld_e1");
    cyc(0, I_LD, 0, 0, R | ZLOO | MARI, "ld_e2");
    cyc(0, I_LD, 0, 0, R | RD, "ld_e3");
    cyc(0, I_LD, 0, 0, R | RD | MDRI, "ld_e4");
    cyc(0, I_LD, 0, 0, R | MDRO | GA | RIN, "ld_e5");
    fetch(I_BR, "brt");
    cyc(0, I_BR, 0, 0, R | GA | ROUT | CONI, "brt_e0");
    cyc(0, I_BR, 0, 0, R | PCO | YI, "brt_e1");
    cyc(0, I_BR, 0, 0, R | CO | ZI, "brt_e2");
    cyc(0, I_BR, 1, 0, R | ZLOO | PCI, "brt_e3");
    fetch(I_BR, "brn");
    cyc(0, I_BR, 1, 0, R | GA | ROUT | CONI, "brn_e0");
    cyc(0, I_BR, 1, 0, R | PCO | YI, "brn_e1");
    cyc(0, I_BR, 1, 0, R | CO | ZI, "brn_e2");
    cyc(0, I_BR, 0, 0, R, "brn_e3");
    fetch(I_JR, "jr");
    cyc(0, I_JR, 0, 0, R | GA | ROUT | PCI, "jr_e0");
    fetch(I_MUL, "mul");
    cyc(0, I_MUL, 0, 0, R | GA | ROUT | YI, "mul_e0");
    cyc(0, I_MUL, 0, 0, R | GB | ROUT | ZI, "mul_e1");
    cyc(0, I_MUL, 0, 0, R | ZLOO | LOI, "mul_e2");
    cyc(0, I_MUL, 0, 0, R | ZHIO | HII, "mul_e3");
    fetch(I_JAL, "jal");
    cyc(0, I_JAL, 0, 0, R | PCO | GA | RIN, "jal_e0");
    cyc(0, I_JAL, 0, 0, R | GB | ROUT | PCI, "jal_e1");
    fetch(I_UND, "undef");
    cyc(0, I_UND, 0, 0, R, "undef_e0");
    fetch(I_ST, "st");
    cyc(0, I_ST, 0, 0, R | GB | BAO | YI, "st_e0");
    cyc(0, I_ST, 0, 0, R | CO | ZI, "st_e1");
    cyc(0, I_ST, 0, 0, R | ZLOO | MARI, "st_e2");
    cyc(0, I_ST, 0, 0, R | GA | ROUT | MDRI, "st_e3");
    cyc(1, I_ST, 0, 0, R, "st_write_reset");
    cyc(1, I_ST, 0, 0, R, "st_reset_hold");
    cyc(0, I_NOP, 0, 0, R, "st_rst_state");
    fetch(I_ADD, "addstop");
    cyc(0, I_ADD, 0, 0, R | GB | ROUT | YI, "addstop_e0");
    cyc(0, I_ADD, 0, 0, R | GC | ROUT | ZI, "addstop_e1");
    cyc(0, I_ADD, 0, 1, R | ZLOO | GA | RIN, "addstop_e2");
    for (int k = 0; k < 4; k++) cyc(0, I_NOP, 1, 0, '0, "stop_halted");
    reset_release(1);
    fetch(I_HALT, "halt");
    for (int k = 0; k < 4; k++) cyc(0, I_ADD, 0, 0, '0, "halt_halted");
    reset_release(2);
    fetch(I_NOP, "post");
    for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: got=%0d pending exp=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
